// File: rtl/tpu_ctrl_pkg.sv
// Control constants and FSM encoding shared by the TPU run sequencer and the TPU top level.
package tpu_ctrl_pkg;
  localparam int TPU_ADDR_W      = 10;
  localparam int TPU_FIFO_ADDR_W = 2;
  localparam int TPU_MATRIX_SIZE = 8;
  localparam int TPU_RESULT_LAT  = 17;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_WADDR  = 3'd1;
  localparam state_t S_WLOAD  = 3'd2;
  localparam state_t S_STREAM = 3'd3;
  localparam state_t S_DRAIN  = 3'd4;
  localparam state_t S_DONE   = 3'd5;
endpackage

// File: rtl/tpu_valid_delay_line.sv
// Fixed-depth valid shift register aligning UB issue strobes with result-row arrival.
module tpu_valid_delay_line #(
  parameter int DEPTH = 17
) (
  input  logic clk,
  input  logic rstn,
  input  logic vld_in,
  output logic vld_out,
  output logic vld_pre
);
  logic [DEPTH:1] vld_pipe;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[DEPTH-1:1], vld_in};
  end

  assign vld_out = vld_pipe[DEPTH];
  // One cycle early tap, used to stage the write address into a register.
  assign vld_pre = vld_pipe[DEPTH-1];
endmodule

// File: rtl/tpu_run_sequencer.sv
// Job sequencer for the 8x8 TPU: weight tile load, UB streaming and aligned result writes.
module tpu_run_sequencer import tpu_ctrl_pkg::*; #(
  parameter int ADDRESSSIZE      = TPU_ADDR_W,
  parameter int ADDRESSSIZE_fifo = TPU_FIFO_ADDR_W,
  parameter int RESULT_LAT       = TPU_RESULT_LAT
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        start,
  input  logic [ADDRESSSIZE_fifo-1:0] cfg_weight_tile,
  input  logic [ADDRESSSIZE-1:0]      cfg_ub_base,
  input  logic [ADDRESSSIZE-1:0]      cfg_res_base,
  input  logic [ADDRESSSIZE:0]        cfg_num_vec,
  output logic [ADDRESSSIZE_fifo-1:0] fifo_address,
  output logic                        we_rl,
  output logic [ADDRESSSIZE-1:0]      ub_address,
  output logic                        ub_read_valid,
  output logic                        res_write_enable,
  output logic [ADDRESSSIZE-1:0]      res_address,
  output logic                        busy,
  output logic                        done
);
  localparam int AW = ADDRESSSIZE;

  state_t          state_q, state_d;
  logic [AW-1:0]   ub_base_q, ub_addr_q, res_addr_q, wr_ptr_q;
  logic [AW:0]     num_vec_q, issue_cnt_q, outst_q, outst_d;
  logic [ADDRESSSIZE_fifo-1:0] fifo_addr_q;
  logic            accept, issue, last_issue, wr_pre;

  assign accept     = (state_q == S_IDLE) && start;
  assign issue      = (state_q == S_STREAM);
  assign last_issue = issue && (issue_cnt_q == num_vec_q - (AW+1)'(1));

  tpu_valid_delay_line #(.DEPTH(RESULT_LAT)) u_dly (
    .clk     (clk),
    .rstn    (rstn),
    .vld_in  (issue),
    .vld_out (res_write_enable),
    .vld_pre (wr_pre)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = (cfg_num_vec == '0) ? S_DONE : S_WADDR;
      S_WADDR:  state_d = S_WLOAD;
      S_WLOAD:  state_d = S_STREAM;
      S_STREAM: if (last_issue) state_d = S_DRAIN;
      // Look at next-cycle count so done lands right after the final write.
      S_DRAIN:  if (outst_d == '0) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    we_rl         = 1'b0;
    ub_read_valid = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state_q)
      S_WADDR:  busy = 1'b1;
      S_WLOAD:  begin busy = 1'b1; we_rl = 1'b1; end
      S_STREAM: begin busy = 1'b1; ub_read_valid = 1'b1; end
      S_DRAIN:  busy = 1'b1;
      S_DONE:   done = 1'b1;
      default:  ;
    endcase
  end

  always_comb begin
    outst_d = outst_q;
    case ({issue, res_write_enable})
      2'b10:   outst_d = outst_q + (AW+1)'(1);
      2'b01:   outst_d = outst_q - (AW+1)'(1);
      default: outst_d = outst_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ub_base_q   <= '0;
      num_vec_q   <= '0;
      fifo_addr_q <= '0;
      wr_ptr_q    <= '0;
      issue_cnt_q <= '0;
      ub_addr_q   <= '0;
      res_addr_q  <= '0;
      outst_q     <= '0;
    end else begin
      outst_q <= outst_d;
      if (accept) begin
        ub_base_q   <= cfg_ub_base;
        num_vec_q   <= cfg_num_vec;
        fifo_addr_q <= cfg_weight_tile;
        wr_ptr_q    <= cfg_res_base;
        issue_cnt_q <= '0;
      end
      if (state_q == S_WLOAD) ub_addr_q <= ub_base_q;
      if (issue) begin
        issue_cnt_q <= issue_cnt_q + (AW+1)'(1);
        if (!last_issue) ub_addr_q <= ub_addr_q + AW'(1);
      end
      // Stage the write address the cycle before the strobe; it then holds until the next write.
      if (wr_pre) begin
        res_addr_q <= wr_ptr_q;
        wr_ptr_q   <= wr_ptr_q + AW'(1);
      end
    end
  end

  assign fifo_address = fifo_addr_q;
  assign ub_address   = ub_addr_q;
  assign res_address  = res_addr_q;
endmodule

// File: tb/tb_tpu_run_sequencer.sv
// Scoreboard bench for tpu_run_sequencer: job-level timing model, randomized jobs and start noise.
module tb_tpu_run_sequencer;
  localparam int AW  = 10;
  localparam int FW  = 2;
  localparam int LAT = 17;

  logic          clk = 1'b0, rstn = 1'b0, start = 1'b0;
  logic [FW-1:0] cfg_weight_tile = '0;
  logic [AW-1:0] cfg_ub_base = '0, cfg_res_base = '0;
  logic [AW:0]   cfg_num_vec = '0;
  logic [FW-1:0] fifo_address;
  logic [AW-1:0] ub_address, res_address;
  logic          we_rl, ub_read_valid, res_write_enable, busy, done;

  tpu_run_sequencer dut (
    .clk(clk), .rstn(rstn), .start(start),
    .cfg_weight_tile(cfg_weight_tile), .cfg_ub_base(cfg_ub_base),
    .cfg_res_base(cfg_res_base), .cfg_num_vec(cfg_num_vec),
    .fifo_address(fifo_address), .we_rl(we_rl), .ub_address(ub_address),
    .ub_read_valid(ub_read_valid), .res_write_enable(res_write_enable),
    .res_address(res_address), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; int v; } ev_t;
  // 0: we_rl (tile), 1: ub issue, 2: result write, 3: done
  ev_t exp_q[4][$];
  int  tests = 0, fails = 0;
  int  free_at = 0, busy_from = -1, busy_to = -2;

  task automatic chk(string name, int got, int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, got, want);
    end
  endtask

  task automatic observe(int k, string name, int v);
    ev_t e;
    if (exp_q[k].size() == 0) begin
      tests++; fails++;
      $display("FAIL %s unexpected @cyc %0d value %0d", name, cyc, v);
    end else begin
      e = exp_q[k].pop_front();
      chk({name, "_cycle"}, cyc, e.c);
      chk({name, "_value"}, v, e.v);
    end
  endtask

  // Job timeline: weights load 2 cycles after acceptance, vectors stream from +3,
  // each result lands LAT later, done follows the last result.
  task automatic accept_job(int c, int tile, int ub, int res, int n);
    if (n == 0) begin
      exp_q[3].push_back('{c + 1, 0});
      free_at = c + 2;
    end else begin
      exp_q[0].push_back('{c + 2, tile});
      for (int i = 0; i < n; i++) begin
        exp_q[1].push_back('{c + 3 + i, (ub + i) % (1 << AW)});
        exp_q[2].push_back('{c + 3 + i + LAT, (res + i) % (1 << AW)});
      end
      exp_q[3].push_back('{c + 3 + n + LAT, 0});
      busy_from = c + 1;
      busy_to   = c + 2 + n + LAT;
      free_at   = c + 4 + n + LAT;
    end
  endtask

  task automatic run_cycle(bit s, int tile, int ub, int res, int n);
    start           = s;
    cfg_weight_tile = FW'(tile);
    cfg_ub_base     = AW'(ub);
    cfg_res_base    = AW'(res);
    cfg_num_vec     = (AW+1)'(n);
    if (s && rstn && cyc >= free_at) accept_job(cyc, tile, ub, res, n);
    @(posedge clk); #1;
  endtask

  task automatic junk_cycle(bit s);
    run_cycle(s, $urandom_range(0, 3), $urandom_range(0, 1023), $urandom_range(0, 1023),
              $urandom_range(0, 1024));
  endtask

  task automatic wait_free(bit noisy);
    while (cyc < free_at) junk_cycle(noisy && ($urandom_range(0, 2) == 0));
  endtask

  task automatic check_quiet(string tag);
    chk({tag, "_we_rl"}, we_rl, 0);
    chk({tag, "_ub_valid"}, ub_read_valid, 0);
    chk({tag, "_res_we"}, res_write_enable, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (we_rl)            observe(0, "we_rl", int'(fifo_address));
      if (ub_read_valid)    observe(1, "ub", int'(ub_address));
      if (res_write_enable) observe(2, "res", int'(res_address));
      if (done)             observe(3, "done", 0);
      chk("busy", int'(busy), int'(cyc >= busy_from && cyc <= busy_to));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired @cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    // Reset held with start asserted
    rstn = 1'b0;
    start = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check_quiet("reset");
      chk("reset_fifo", int'(fifo_address), 0);
      chk("reset_ub_addr", int'(ub_address), 0);
      chk("reset_res_addr", int'(res_address), 0);
    end
    start = 1'b0;
    rstn  = 1'b1;
    free_at = cyc;
    repeat (5) junk_cycle(1'b0);

    // Reference job
    run_cycle(1'b1, 2, 'h10, 'h40, 4);
    wait_free(1'b0);
    // Empty job
    run_cycle(1'b1, 1, 'h20, 'h30, 0);
    wait_free(1'b0);
    // Address wrap
    run_cycle(1'b1, 3, 'h3FE, 'h3FF, 3);
    wait_free(1'b0);
    // Start noise and cfg changes throughout a job, including the done cycle
    run_cycle(1'b1, 1, 'h100, 'h200, 6);
    while (cyc < free_at) junk_cycle(1'b1);
    // Back-to-back: start offered on the first idle cycle
    run_cycle(1'b1, 0, 'h005, 'h3F0, 2);
    wait_free(1'b0);
    run_cycle(1'b1, 2, 'h006, 'h3F8, 1);
    wait_free(1'b0);

    // Reset mid-job drops everything in flight
    c0 = cyc;
    run_cycle(1'b1, 2, 'h10, 'h40, 4);
    while (cyc < c0 + 10) junk_cycle(1'b0);
    rstn = 1'b0;
    for (int k = 0; k < 4; k++) exp_q[k].delete();
    busy_from = -1;
    busy_to   = -2;
    #1;
    check_quiet("midreset");
    repeat (2) begin
      @(posedge clk); #1;
      check_quiet("midreset_hold");
    end
    rstn = 1'b1;
    free_at = cyc;
    repeat (3) junk_cycle(1'b0);
    run_cycle(1'b1, 1, 'h50, 'h60, 4);
    wait_free(1'b0);

    // Maximum-length job
    run_cycle(1'b1, 3, 'h3F0, 'h200, 1024);
    wait_free(1'b1);

    // Randomized jobs with random gaps and stray starts
    for (int j = 0; j < 40; j++) begin
      int gap;
      gap = $urandom_range(0, 3);
      repeat (gap) junk_cycle(1'b0);
      run_cycle(1'b1, $urandom_range(0, 3), $urandom_range(0, 1023),
                $urandom_range(0, 1023), $urandom_range(0, 24));
      wait_free(1'b1);
    end

    repeat (LAT + 5) junk_cycle(1'b0);
    for (int k = 0; k < 4; k++) chk($sformatf("leftover_q%0d", k), exp_q[k].size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
